demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//  1-to-4 registered demultiplexer; the inverse of the 4:1 mux in the lab datapath.
//  Routes each accepted input word to the output channel chosen by Sel.
//  Each channel has a one-entry holding register and a valid/ready handshake.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  WIDTH    8   data word width in bits
//  CNTW     8   width of the accepted-word counter
// PORTS
//  Clk          in   1        single clock, all state updates on rising edge
//  Rst          in   1        synchronous reset, active-high
//  In           in   WIDTH    input data word
//  Sel          in   2        destination channel (0..3) for In
//  InValid      in   1        producer presents In/Sel this cycle
//  InReady      out  1        block can accept In this cycle
//  Out0..Out3   out  WIDTH    per-channel registered data
//  OutValid     out  4        bit k: Outk holds an undelivered word
//  OutReady     in   4        bit k: consumer k takes Outk this cycle
//  AcceptCount  out  CNTW     number of words accepted since reset
// BEHAVIOUR
//  Clock/reset: one clock (Clk); Rst is synchronous and active-high.
//  Reset: at the first Clk edge with Rst=1, OutValid=4'b0000, Out0..Out3=0, AcceptCount=0.
//   Held words are discarded; no handshake completes while Rst=1.
//  Per-channel state k: EMPTY (OutValid[k]=0) or FULL (OutValid[k]=1).
//  InReady = !OutValid[Sel] | OutReady[Sel]. It is combinational in Sel, OutValid
//   and OutReady, and does not depend on InValid.
//  Accept = InValid & InReady (& !Rst).
//   On Accept: Out[Sel] <= In; OutValid[Sel] <= 1; AcceptCount <= AcceptCount+1.
//  Deliver k = OutValid[k] & OutReady[k].
//   On Deliver k without Accept to k: OutValid[k] <= 0. Out[k] keeps its value.
//  Simultaneous Deliver k and Accept to k (FULL & OutReady): the new word replaces
//   the old one; OutValid[k] stays 1. This gives full throughput, 1 word/cycle.
//  Transitions:
//   EMPTY->FULL on Accept to k.
//   FULL->EMPTY on Deliver k without Accept to k.
//   FULL->FULL on Accept to k with OutReady[k]=1.
//   FULL with OutReady[k]=0 and Sel=k: InReady=0; the producer must hold In and Sel.
//  Latency: a word accepted at edge N is visible on Out[Sel] with OutValid set
//   after edge N. Data never passes combinationally from In to Outk.
//  Channels are independent: a stalled channel never blocks delivery on others.
//   It only blocks input while Sel points at it.
//  Channels not selected, or with InValid=0, hold Out and OutValid unless delivered.
//  AcceptCount wraps modulo 2^CNTW, e.g. 255 -> 0 for CNTW=8. There is no saturation.
//  Sel with InValid=0 has no effect on state; InReady still reflects Sel.
//  Reset mid-transfer: Rst wins over Accept and Deliver in the same cycle.
// TESTING
//  T1 reset: Rst=1 one cycle with InValid=1, In=8'hAA
//   -> OutValid=0000, Out0..3=00, AcceptCount=0.
//  T2 walking 1: OutReady=1111; Sel=0..3 on consecutive cycles, In=01,02,04,08
//   -> one cycle later OutValid is 0001, 0010, 0100, 1000 in turn
//   -> Outk matches its word; AcceptCount=4.
//  T3 stall: OutReady=0000; Sel=2, In=5A accepted
//   -> OutValid=0100, InReady=0 while Sel=2;
//   -> Sel=1, In=3C is still accepted (OutValid=0110);
//   -> raise OutReady[2] and Out2=5A is delivered.
//  T4 back-to-back: OutReady[3]=1, Sel=3, In=10,11,12 on three consecutive cycles
//   -> InReady=1 every cycle; Out3 shows 10, 11, 12; OutValid[3]=1 throughout.
//  T5 wrap: 256 accepts to random channels with OutReady=1111
//   -> AcceptCount returns to 0; a scoreboard confirms every word reached channel Sel.
//  T6 reset mid-operation: all four channels FULL, OutReady=0, then assert Rst
//   -> OutValid=0000 next cycle and InReady=1 for any Sel.

Source files
------------

// File: rtl/demux_stream.sv
// 1-to-4 registered stream demultiplexer: each accepted word lands in the holding
// register of the channel picked by sel and is handed off with a per-channel valid/ready.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNTW-1:0]  accept_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready depends only on sel and the selected channel's state/out_ready, never on
    // in_valid; a producer seeing in_ready=0 with in_valid=1 holds in and sel.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t            state_q [4];
    chan_state_t            state_d [4];
    logic [WIDTH-1:0]       data_q  [4];
    logic [CNTW-1:0]        count_q;
    logic                   accept;
    logic [3:0]             deliver;

    always_comb begin
        in_ready = (state_q[sel] == EMPTY) | out_ready[sel];
        accept   = in_valid & in_ready & ~rst;
        deliver  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            deliver[k] = (state_q[k] == FULL) & out_ready[k];
            // An accept into a channel that delivers this cycle keeps it FULL.
            if (accept && (sel == 2'(k))) begin
                state_d[k] = FULL;
            end else if (deliver[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
            end
            if (accept) begin
                data_q[sel] <= in;
                count_q     <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign out0         = data_q[0];
    assign out1         = data_q[1];
    assign out2         = data_q[2];
    assign out3         = data_q[3];
    assign accept_count = count_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: hand-computed vector table for the directed sequences, then
// randomized traffic against a per-channel queue model of the stream.
module tb_demux_stream;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0, out1, out2, out3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   accept_count;

    demux_stream #(.WIDTH(W), .CNTW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (din),
        .sel          (sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out0         (out0),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - 0 assertions evaluated, 1 failures");
        $fatal(1, "watchdog");
    end

    // scoreboard and model state
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q [4][$];
    bit   [3:0]   m_valid;
    logic [W-1:0] m_data [4];
    int           m_cnt;
    logic         last_ir;

    typedef struct {
        logic       r;
        logic       iv;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       chk_ir;
        logic       exp_ir;
        logic [3:0] exp_ov;
        logic [7:0] exp_cnt;
        logic [1:0] ch;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] s,
                                input logic [7:0] d, input logic [3:0] ordy,
                                input logic chk_ir, input logic exp_ir,
                                input logic [3:0] exp_ov, input logic [7:0] exp_cnt,
                                input logic [1:0] ch, input logic [7:0] exp_dat);
        vec_t v;
        v.r = r; v.iv = iv; v.s = s; v.d = d; v.ordy = ordy;
        v.chk_ir = chk_ir; v.exp_ir = exp_ir; v.exp_ov = exp_ov;
        v.exp_cnt = exp_cnt; v.ch = ch; v.exp_dat = exp_dat;
        return v;
    endfunction

    function automatic logic [W-1:0] get_out(input int k);
        case (k)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one clock cycle of stimulus, checked against the model
    task automatic step(input logic r, input logic iv, input logic [1:0] s,
                        input logic [W-1:0] d, input logic [3:0] ordy, input bit chk_ir);
        logic   exp_ir;
        logic   acc;
        logic [W-1:0] w;
        rst = r; in_valid = iv; sel = s; din = d; out_ready = ordy;
        @(negedge clk);
        exp_ir  = !m_valid[s] || ordy[s];
        last_ir = in_ready;
        if (chk_ir) check("in_ready", 32'(in_ready), 32'(exp_ir));
        acc = iv && exp_ir && !r;
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && ordy[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("sb_underflow", 32'(k + 1), 32'd0);
                    end else begin
                        w = exp_q[k].pop_front();
                        check("deliver_data", 32'(get_out(k)), 32'(w));
                    end
                end
            end
        end
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                m_data[k] = '0;
            end
            m_valid = 4'b0000;
            m_cnt   = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
            end
            if (acc) begin
                m_valid[s] = 1'b1;
                m_data[s]  = d;
                m_cnt      = (m_cnt + 1) % 256;
                exp_q[s].push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("accept_count", 32'(accept_count), 32'(m_cnt));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out%0d", k), 32'(get_out(k)), 32'(m_data[k]));
        end
    endtask

    task automatic run_vec(input vec_t v);
        step(v.r, v.iv, v.s, v.d, v.ordy, v.chk_ir);
        if (v.chk_ir) check("vec_in_ready", 32'(last_ir), 32'(v.exp_ir));
        check("vec_out_valid", 32'(out_valid), 32'(v.exp_ov));
        check("vec_count", 32'(accept_count), 32'(v.exp_cnt));
        check("vec_data", 32'(get_out(int'(v.ch))), 32'(v.exp_dat));
    endtask

    initial begin
        logic         h_iv;
        logic [1:0]   h_s;
        logic [W-1:0] h_d;
        logic [3:0]   h_r;

        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; din = '0; out_ready = 4'b0000;
        m_valid = 4'b0000; m_cnt = 0; last_ir = 1'b0;
        for (int k = 0; k < 4; k++) m_data[k] = '0;

        //               r  iv  s  d      ordy     chk ir  ov       cnt  ch dat
        vecs.push_back(mk(1, 1, 0, 8'hAA, 4'b0000, 0, 0, 4'b0000, 0, 0, 8'h00)); // reset
        vecs.push_back(mk(0, 1, 0, 8'h01, 4'b1111, 1, 1, 4'b0001, 1, 0, 8'h01)); // walking 1
        vecs.push_back(mk(0, 1, 1, 8'h02, 4'b1111, 1, 1, 4'b0010, 2, 1, 8'h02));
        vecs.push_back(mk(0, 1, 2, 8'h04, 4'b1111, 1, 1, 4'b0100, 3, 2, 8'h04));
        vecs.push_back(mk(0, 1, 3, 8'h08, 4'b1111, 1, 1, 4'b1000, 4, 3, 8'h08));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 4, 3, 8'h08)); // drain
        vecs.push_back(mk(0, 1, 2, 8'h5A, 4'b0000, 1, 1, 4'b0100, 5, 2, 8'h5A)); // stall
        vecs.push_back(mk(0, 1, 2, 8'h77, 4'b0000, 1, 0, 4'b0100, 5, 2, 8'h5A));
        vecs.push_back(mk(0, 1, 1, 8'h3C, 4'b0000, 1, 1, 4'b0110, 6, 1, 8'h3C));
        vecs.push_back(mk(0, 0, 2, 8'h00, 4'b0100, 1, 1, 4'b0010, 6, 2, 8'h5A));
        vecs.push_back(mk(0, 1, 3, 8'h10, 4'b1000, 1, 1, 4'b1010, 7, 3, 8'h10)); // back-to-back
        vecs.push_back(mk(0, 1, 3, 8'h11, 4'b1000, 1, 1, 4'b1010, 8, 3, 8'h11));
        vecs.push_back(mk(0, 1, 3, 8'h12, 4'b1000, 1, 1, 4'b1010, 9, 3, 8'h12));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 9, 3, 8'h12));

        foreach (vecs[i]) run_vec(vecs[i]);

        // wrap: 256 accepts from a clean count
        step(1, 0, 0, '0, 4'b0000, 1);
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 2'($urandom_range(0, 3)), W'($urandom_range(0, 255)), 4'b1111, 1);
        end
        check("wrap_count", 32'(accept_count), 32'd0);

        // random traffic; the producer holds in/sel while stalled
        h_iv = 1'b0; h_s = 2'd0; h_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(h_iv && !last_ir)) begin
                h_iv = 1'($urandom_range(0, 3) != 0);
                h_s  = 2'($urandom_range(0, 3));
                h_d  = W'($urandom_range(0, 255));
            end
            h_r = 4'($urandom_range(0, 15));
            step(0, h_iv, h_s, h_d, h_r, 1);
        end

        // reset mid-operation with all channels full
        step(0, 0, 0, '0, 4'b1111, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 2'(k), W'(8'hC0 + k), 4'b0000, 1);
        check("all_full", 32'(out_valid), 32'hF);
        step(1, 1, 2, 8'hEE, 4'b1111, 1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 2'(k), '0, 4'b0000, 1);
            check("rst_in_ready", 32'(last_ir), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
